fc_load_ctrl: RTL and testbench

- Operand-load sequencer for the fully-connected layer.
- After a start pulse, it reads the layer's input data and weight matrix element-serially from a shared single-port operand SRAM through a req/gnt port, then presents them to the FC datapath with data_en/weight_en.
- When the datapath raises bias_rq, it fetches the bias vector and presents it with bias_en. It holds all operands stable until the datapath reports result_valid, then pulses done.

---
 rtl/fc_pkg.sv | 23 ++
 rtl/fc_mem_rd_port.sv | 86 ++++++++
 rtl/fc_load_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_fc_load_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the fully-connected operand loader.
package fc_pkg;

    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {
        StIdle,
        StLdDw,
        StHoldDw,
        StLdB,
        StHoldB,
        StDone
    } fc_ld_state_e;

    function automatic int unsigned nd(input int unsigned batch, input int unsigned feat);
        return batch * feat;
    endfunction

    function automatic int unsigned nw(input int unsigned feat, input int unsigned outs);
        return feat * outs;
    endfunction

endpackage

// File: rtl/fc_mem_rd_port.sv
// Element-serial read port: issues req/addr over up to two address segments with
// stall-on-no-gnt, and returns a one-cycle-delayed rvalid tagged with the element index.
module fc_mem_rd_port #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              launch,
    input  logic [ADDR_W-1:0] base0,
    input  logic [IDX_W-1:0]  len0,
    input  logic [ADDR_W-1:0] base1,
    input  logic [IDX_W-1:0]  len1,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    output logic              rvalid,
    output logic [IDX_W-1:0]  rtag
);

    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              rvalid_q, rvalid_d;
    logic [IDX_W-1:0]  rtag_q, rtag_d;
    logic              accept;
    logic [IDX_W-1:0]  idx_inc;
    logic [IDX_W-1:0]  total;

    function automatic logic [ADDR_W-1:0] addr_of(
        input logic [IDX_W-1:0]  idx,
        input logic [IDX_W-1:0]  l0,
        input logic [ADDR_W-1:0] b0,
        input logic [ADDR_W-1:0] b1
    );
        if (idx < l0) begin
            return b0 + ADDR_W'(idx);
        end
        return b1 + ADDR_W'(idx - l0);
    endfunction

    always_comb begin
        accept   = req_q & mem_gnt;
        total    = len0 + len1;
        idx_inc  = idx_q + IDX_W'(1);
        req_d    = req_q;
        addr_d   = addr_q;
        idx_d    = idx_q;
        rvalid_d = accept;
        rtag_d   = idx_q;
        if (launch) begin
            req_d  = 1'b1;
            idx_d  = '0;
            addr_d = addr_of('0, len0, base0, base1);
        end else if (accept) begin
            idx_d = idx_inc;
            if (idx_inc == total) begin
                req_d = 1'b0;
            end else begin
                addr_d = addr_of(idx_inc, len0, base0, base1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= 1'b0;
            addr_q   <= '0;
            idx_q    <= '0;
            rvalid_q <= 1'b0;
            rtag_q   <= '0;
        end else begin
            req_q    <= req_d;
            addr_q   <= addr_d;
            idx_q    <= idx_d;
            rvalid_q <= rvalid_d;
            rtag_q   <= rtag_d;
        end
    end

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign rvalid   = rvalid_q;
    assign rtag     = rtag_q;

endmodule

// File: rtl/fc_load_ctrl.sv
// FC layer operand-load sequencer: stages data and weights, then bias on request,
// and holds everything stable until the datapath reports its result.
module fc_load_ctrl import fc_pkg::*; #(
    parameter int unsigned BATCH  = 1,
    parameter int unsigned FEAT   = 3,
    parameter int unsigned OUTS   = 2,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DW     = fc_pkg::DW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        data_base,
    input  logic [ADDR_W-1:0]        weight_base,
    input  logic [ADDR_W-1:0]        bias_base,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_gnt,
    input  logic [DW-1:0]            mem_rdata,
    output logic [BATCH*FEAT*DW-1:0] data_flat,
    output logic [FEAT*OUTS*DW-1:0]  weight_flat,
    output logic [OUTS*DW-1:0]       bias_flat,
    output logic                     data_en,
    output logic                     weight_en,
    output logic                     bias_en,
    input  logic                     bias_rq,
    input  logic                     result_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned ND    = nd(BATCH, FEAT);
    localparam int unsigned NW    = nw(FEAT, OUTS);
    localparam int unsigned NT    = ND + NW;
    localparam int unsigned IDX_W = $clog2(NT + 1);

    fc_ld_state_e state_q, state_d;

    logic [ADDR_W-1:0]        data_base_q, data_base_d;
    logic [ADDR_W-1:0]        weight_base_q, weight_base_d;
    logic [ADDR_W-1:0]        bias_base_q, bias_base_d;
    logic                     rq_seen_q, rq_seen_d;
    logic                     en_dw_q, en_dw_d;
    logic                     bias_en_q, bias_en_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [BATCH*FEAT*DW-1:0] data_flat_q, data_flat_d;
    logic [FEAT*OUTS*DW-1:0]  weight_flat_q, weight_flat_d;
    logic [OUTS*DW-1:0]       bias_flat_q, bias_flat_d;

    logic              launch;
    logic [ADDR_W-1:0] seg0_base, seg1_base;
    logic [IDX_W-1:0]  seg0_len, seg1_len;
    logic              rd_valid;
    logic [IDX_W-1:0]  rd_tag;
    logic              last_dw, last_b;

    // In IDLE the port sees the live base inputs so the first address is ready right after start.
    always_comb begin
        seg0_base = bias_base_q;
        seg1_base = bias_base_q;
        seg0_len  = IDX_W'(OUTS);
        seg1_len  = '0;
        if (state_q == StIdle) begin
            seg0_base = data_base;
            seg1_base = weight_base;
            seg0_len  = IDX_W'(ND);
            seg1_len  = IDX_W'(NW);
        end else if (state_q == StLdDw) begin
            seg0_base = data_base_q;
            seg1_base = weight_base_q;
            seg0_len  = IDX_W'(ND);
            seg1_len  = IDX_W'(NW);
        end
    end

    assign launch = ((state_q == StIdle) && start) ||
                    ((state_q == StHoldDw) && (bias_rq || rq_seen_q));

    fc_mem_rd_port #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_rd_port (
        .clk      (clk),
        .rst_n    (rst_n),
        .launch   (launch),
        .base0    (seg0_base),
        .len0     (seg0_len),
        .base1    (seg1_base),
        .len1     (seg1_len),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_gnt  (mem_gnt),
        .rvalid   (rd_valid),
        .rtag     (rd_tag)
    );

    assign last_dw = rd_valid && (rd_tag == IDX_W'(NT - 1));
    assign last_b  = rd_valid && (rd_tag == IDX_W'(OUTS - 1));

    always_comb begin
        state_d       = state_q;
        data_base_d   = data_base_q;
        weight_base_d = weight_base_q;
        bias_base_d   = bias_base_q;
        rq_seen_d     = rq_seen_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d       = StLdDw;
                    data_base_d   = data_base;
                    weight_base_d = weight_base;
                    bias_base_d   = bias_base;
                end
            end
            StLdDw: begin
                if (bias_rq) begin
                    rq_seen_d = 1'b1;
                end
                if (last_dw) begin
                    state_d = StHoldDw;
                end
            end
            StHoldDw: begin
                if (bias_rq || rq_seen_q) begin
                    state_d = StLdB;
                end
            end
            StLdB: begin
                if (last_b) begin
                    state_d = StHoldB;
                end
            end
            StHoldB: begin
                if (result_valid) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                rq_seen_d = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        en_dw_d   = (state_d == StHoldDw);
        bias_en_d = (state_d == StHoldB);
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
    end

    // Return-path write-back; the tag selects the element slot.
    always_comb begin
        data_flat_d   = data_flat_q;
        weight_flat_d = weight_flat_q;
        bias_flat_d   = bias_flat_q;
        if (rd_valid) begin
            if (state_q == StLdDw) begin
                if (rd_tag < IDX_W'(ND)) begin
                    data_flat_d[int'(rd_tag)*DW +: DW] = mem_rdata;
                end else begin
                    weight_flat_d[(int'(rd_tag) - int'(ND))*DW +: DW] = mem_rdata;
                end
            end else if (state_q == StLdB) begin
                bias_flat_d[int'(rd_tag)*DW +: DW] = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            data_base_q   <= '0;
            weight_base_q <= '0;
            bias_base_q   <= '0;
            rq_seen_q     <= 1'b0;
            en_dw_q       <= 1'b0;
            bias_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            data_flat_q   <= '0;
            weight_flat_q <= '0;
            bias_flat_q   <= '0;
        end else begin
            state_q       <= state_d;
            data_base_q   <= data_base_d;
            weight_base_q <= weight_base_d;
            bias_base_q   <= bias_base_d;
            rq_seen_q     <= rq_seen_d;
            en_dw_q       <= en_dw_d;
            bias_en_q     <= bias_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            data_flat_q   <= data_flat_d;
            weight_flat_q <= weight_flat_d;
            bias_flat_q   <= bias_flat_d;
        end
    end

    assign data_flat   = data_flat_q;
    assign weight_flat = weight_flat_q;
    assign bias_flat   = bias_flat_q;
    assign data_en     = en_dw_q;
    assign weight_en   = en_dw_q;
    assign bias_en     = bias_en_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fc_load_ctrl.sv
// Self-checking bench for fc_load_ctrl: memory model logs accepted addresses, which are
// checked against an expected-address scoreboard filled when each job is started.
module tb_fc_load_ctrl;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   data_base = '0;
    logic [15:0]   weight_base = '0;
    logic [15:0]   bias_base = '0;
    logic          mem_req;
    logic [15:0]   mem_addr;
    logic          mem_gnt = 1'b1;
    logic [31:0]   mem_rdata = '0;
    logic [95:0]   data_flat;
    logic [191:0]  weight_flat;
    logic [63:0]   bias_flat;
    logic          data_en, weight_en, bias_en;
    logic          bias_rq = 1'b0;
    logic          result_valid = 1'b0;
    logic          busy, done;

    int n_chk = 0;
    int n_pass = 0;

    logic [15:0] exp_q[$];
    logic [15:0] acc_q[$];
    logic [31:0] mem [logic [15:0]];

    logic [95:0]  data_exp = {32'd3, 32'd2, 32'd1};
    logic [63:0]  bias_exp = {32'd101, 32'd100};
    logic [191:0] wt_exp;
    logic [191:0] wt_wrap_exp;

    always #5 clk = ~clk;

    fc_load_ctrl #(
        .BATCH  (1),
        .FEAT   (3),
        .OUTS   (2),
        .ADDR_W (16),
        .DW     (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .data_base    (data_base),
        .weight_base  (weight_base),
        .bias_base    (bias_base),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rdata    (mem_rdata),
        .data_flat    (data_flat),
        .weight_flat  (weight_flat),
        .bias_flat    (bias_flat),
        .data_en      (data_en),
        .weight_en    (weight_en),
        .bias_en      (bias_en),
        .bias_rq      (bias_rq),
        .result_valid (result_valid),
        .busy         (busy),
        .done         (done)
    );

    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hDEAD0000 | {16'h0, a};
    endfunction

    always @(posedge clk) begin
        if (rst_n && mem_req && mem_gnt) begin
            acc_q.push_back(mem_addr);
            mem_rdata <= mem_rd(mem_addr);
        end
    end

    function automatic logic cond(input int sel, input logic [15:0] v);
        case (sel)
            0:       return data_en === 1'b1;
            1:       return bias_en === 1'b1;
            2:       return done === 1'b1;
            default: return (mem_req === 1'b1) && (mem_addr === v);
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic [15:0] v, input int budget,
                            input string name, output int cyc);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cond(sel, v)) break;
            if (cyc >= budget) begin
                n_chk++;
                $display("FAIL %s: event not seen within %0d cycles", name, budget);
                break;
            end
        end
    endtask

    task automatic do_start(input logic [15:0] d, input logic [15:0] w, input logic [15:0] b);
        acc_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(d + 16'(i));
        for (int i = 0; i < 6; i++) exp_q.push_back(w + 16'(i));
        @(negedge clk);
        data_base = d;
        weight_base = w;
        bias_base = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_job();
        int c;
        bias_rq = 1'b1;
        @(negedge clk);
        bias_rq = 1'b0;
        wait_for(1, 16'h0, 20, "fin_bias_en", c);
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({mem_req, busy, done, data_en, weight_en, bias_en} !== 6'b0) begin
            $display("FAIL reset_ctl: got req/busy/done/en=%b, required 000000",
                     {mem_req, busy, done, data_en, weight_en, bias_en});
        end else n_pass++;
        n_chk++;
        if ({data_flat, weight_flat, bias_flat, mem_addr} !== '0) begin
            $display("FAIL reset_data: got nonzero staged data/addr, required all zero");
        end else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({mem_req, busy} !== 2'b00) begin
            $display("FAIL reset_idle: got req/busy=%b, required 00", {mem_req, busy});
        end else n_pass++;
    endtask

    task automatic test_basic();
        int c;
        logic bad;
        logic [15:0] e, a, bad_a, bad_e;
        do_start(16'h0010, 16'h0020, 16'h0030);
        n_chk++;
        if ({mem_req, busy} !== 2'b11 || mem_addr !== 16'h0010) begin
            $display("FAIL basic_first_req: got req/busy=%b addr=%h, required 11 addr=0010",
                     {mem_req, busy}, mem_addr);
        end else n_pass++;
        wait_for(0, 16'h0, 40, "basic_en", c);
        n_chk++;
        if (c !== 10) $display("FAIL basic_latency: got %0d cycles, required 10", c);
        else n_pass++;
        n_chk++;
        bad = 1'b0; bad_a = '0; bad_e = '0;
        if (acc_q.size() != exp_q.size()) bad = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (acc_q.size() > 0) ? acc_q.pop_front() : 16'hxxxx;
            if (a !== e && !bad) begin bad = 1'b1; bad_a = a; bad_e = e; end
        end
        if (bad) $display("FAIL basic_addr_seq: got %h, required %h", bad_a, bad_e);
        else n_pass++;
        n_chk++;
        if (data_flat !== data_exp) $display("FAIL basic_data: got %h, required %h",
                                             data_flat, data_exp);
        else n_pass++;
        n_chk++;
        if (weight_flat !== wt_exp) $display("FAIL basic_weight: got %h, required %h",
                                             weight_flat, wt_exp);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({data_en, weight_en} !== 2'b11) begin
            $display("FAIL basic_hold: got en=%b, required 11", {data_en, weight_en});
        end else n_pass++;
        exp_q.push_back(16'h0030);
        exp_q.push_back(16'h0031);
        bias_rq = 1'b1;
        @(negedge clk);
        bias_rq = 1'b0;
        n_chk++;
        if ({data_en, weight_en, mem_req} !== 3'b001 || mem_addr !== 16'h0030) begin
            $display("FAIL basic_en_drop: got en/req=%b addr=%h, required 001 addr=0030",
                     {data_en, weight_en, mem_req}, mem_addr);
        end else n_pass++;
        wait_for(1, 16'h0, 20, "basic_bias_en", c);
        n_chk++;
        if (c !== 3) $display("FAIL basic_bias_latency: got %0d cycles, required 3", c);
        else n_pass++;
        n_chk++;
        if (bias_flat !== bias_exp) $display("FAIL basic_bias: got %h, required %h",
                                             bias_flat, bias_exp);
        else n_pass++;
        n_chk++;
        bad = 1'b0; bad_a = '0; bad_e = '0;
        if (acc_q.size() != exp_q.size()) bad = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (acc_q.size() > 0) ? acc_q.pop_front() : 16'hxxxx;
            if (a !== e && !bad) begin bad = 1'b1; bad_a = a; bad_e = e; end
        end
        if (bad) $display("FAIL basic_bias_addr: got %h, required %h", bad_a, bad_e);
        else n_pass++;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        n_chk++;
        if ({done, bias_en, busy} !== 3'b101) begin
            $display("FAIL basic_done: got done/bias_en/busy=%b, required 101",
                     {done, bias_en, busy});
        end else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({done, busy} !== 2'b00) begin
            $display("FAIL basic_after_done: got done/busy=%b, required 00", {done, busy});
        end else n_pass++;
        n_chk++;
        if (data_flat !== data_exp || bias_flat !== bias_exp) begin
            $display("FAIL basic_persist: got data=%h bias=%h, required %h %h",
                     data_flat, bias_flat, data_exp, bias_exp);
        end else n_pass++;
    endtask

    task automatic test_stall();
        int c;
        logic bad;
        logic [15:0] e, a, bad_a, bad_e;
        do_start(16'h0010, 16'h0020, 16'h0030);
        wait_for(3, 16'h0021, 20, "stall_reach", c);
        n_chk++;
        if (c !== 4) $display("FAIL stall_reach_cycle: got %0d, required 4", c);
        else n_pass++;
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (mem_req !== 1'b1 || mem_addr !== 16'h0021) begin
                $display("FAIL stall_hold: got req=%b addr=%h, required 1 addr=0021",
                         mem_req, mem_addr);
            end else n_pass++;
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        n_chk++;
        if (mem_addr !== 16'h0022) $display("FAIL stall_resume: got %h, required 0022",
                                            mem_addr);
        else n_pass++;
        wait_for(0, 16'h0, 40, "stall_en", c);
        n_chk++;
        if (c !== 5) $display("FAIL stall_latency: got %0d more cycles, required 5", c);
        else n_pass++;
        n_chk++;
        bad = 1'b0; bad_a = '0; bad_e = '0;
        if (acc_q.size() != exp_q.size()) bad = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (acc_q.size() > 0) ? acc_q.pop_front() : 16'hxxxx;
            if (a !== e && !bad) begin bad = 1'b1; bad_a = a; bad_e = e; end
        end
        if (bad) $display("FAIL stall_addr_seq: got %h, required %h", bad_a, bad_e);
        else n_pass++;
        n_chk++;
        if (weight_flat !== wt_exp) $display("FAIL stall_weight: got %h, required %h",
                                             weight_flat, wt_exp);
        else n_pass++;
        finish_job();
    endtask

    task automatic test_rq_early();
        int c;
        do_start(16'h0010, 16'h0020, 16'h0030);
        wait_for(3, 16'h0012, 20, "early_reach", c);
        bias_rq = 1'b1;
        @(negedge clk);
        bias_rq = 1'b0;
        wait_for(0, 16'h0, 40, "early_en", c);
        n_chk++;
        if (c !== 7) $display("FAIL early_latency: got %0d cycles, required 7", c);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({data_en, mem_req} !== 2'b01 || mem_addr !== 16'h0030) begin
            $display("FAIL early_hold_one: got en/req=%b addr=%h, required 01 addr=0030",
                     {data_en, mem_req}, mem_addr);
        end else n_pass++;
        wait_for(1, 16'h0, 20, "early_bias_en", c);
        n_chk++;
        if (bias_flat !== bias_exp) $display("FAIL early_bias: got %h, required %h",
                                             bias_flat, bias_exp);
        else n_pass++;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        n_chk++;
        if (done !== 1'b1) $display("FAIL early_done: got %b, required 1", done);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_busy_wrap();
        int c;
        logic bad;
        logic [15:0] e, a, bad_a, bad_e;
        do_start(16'h0010, 16'hFFFE, 16'h0030);
        @(negedge clk);
        data_base = 16'h0040;
        weight_base = 16'h0050;
        bias_base = 16'h0060;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_for(0, 16'h0, 40, "wrap_en", c);
        n_chk++;
        bad = 1'b0; bad_a = '0; bad_e = '0;
        if (acc_q.size() != exp_q.size()) bad = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (acc_q.size() > 0) ? acc_q.pop_front() : 16'hxxxx;
            if (a !== e && !bad) begin bad = 1'b1; bad_a = a; bad_e = e; end
        end
        if (bad) $display("FAIL wrap_addr_seq: got %h, required %h", bad_a, bad_e);
        else n_pass++;
        n_chk++;
        if (weight_flat !== wt_wrap_exp || data_flat !== data_exp) begin
            $display("FAIL wrap_operands: got w=%h d=%h, required w=%h d=%h",
                     weight_flat, data_flat, wt_wrap_exp, data_exp);
        end else n_pass++;
        @(negedge clk);
        n_chk++;
        if (data_en !== 1'b1) $display("FAIL wrap_rq_cleared: got en=%b, required 1", data_en);
        else n_pass++;
        finish_job();
        n_chk++;
        if (bias_flat !== bias_exp || busy !== 1'b0) begin
            $display("FAIL wrap_bias: got %h busy=%b, required %h busy=0",
                     bias_flat, busy, bias_exp);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        int c;
        logic bad;
        logic [15:0] e, a, bad_a, bad_e;
        do_start(16'h0010, 16'h0020, 16'h0030);
        wait_for(3, 16'h0022, 20, "rst_reach", c);
        #1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({mem_req, busy, data_en, weight_en, bias_en, done} !== 6'b0 ||
            data_flat !== '0) begin
            $display("FAIL rst_async: got req/busy/en/done=%b data=%h, required 0",
                     {mem_req, busy, data_en, weight_en, bias_en, done}, data_flat);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        do_start(16'h0010, 16'h0020, 16'h0030);
        wait_for(0, 16'h0, 40, "rst_en", c);
        n_chk++;
        if (c !== 10) $display("FAIL rst_latency: got %0d cycles, required 10", c);
        else n_pass++;
        n_chk++;
        bad = 1'b0; bad_a = '0; bad_e = '0;
        if (acc_q.size() != exp_q.size()) bad = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (acc_q.size() > 0) ? acc_q.pop_front() : 16'hxxxx;
            if (a !== e && !bad) begin bad = 1'b1; bad_a = a; bad_e = e; end
        end
        if (bad) $display("FAIL rst_addr_seq: got %h, required %h", bad_a, bad_e);
        else n_pass++;
        n_chk++;
        if (data_flat !== data_exp || weight_flat !== wt_exp) begin
            $display("FAIL rst_operands: got d=%h w=%h, required d=%h w=%h",
                     data_flat, weight_flat, data_exp, wt_exp);
        end else n_pass++;
        finish_job();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) mem[16'h0010 + 16'(i)] = 32'(i + 1);
        for (int i = 0; i < 6; i++) begin
            mem[16'h0020 + 16'(i)] = 32'(10 + i);
            mem[16'hFFFE + 16'(i)] = 32'(200 + i);
            wt_exp[i*32 +: 32] = 32'(10 + i);
            wt_wrap_exp[i*32 +: 32] = 32'(200 + i);
        end
        mem[16'h0030] = 32'd100;
        mem[16'h0031] = 32'd101;

        test_reset();
        test_basic();
        test_stall();
        test_rq_early();
        test_busy_wrap();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
